// File: rtl/audio_pkg.sv
// audio_pkg: player state encoding, default widths and the base-octave note table
// used when AUDIO_NOTE_LUT_EN is defined.
package audio_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int DIV_W_DEF    = 16;
  localparam int DUR_W_DEF    = 8;
  localparam int TICK_DIV_DEF = 50000;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_e;
  // Half periods in 50 MHz clocks for C5..B5; indices 12..15 are rests.
  localparam logic [15:0] NOTE_HALF_PERIOD [16] = '{
    16'd47778, 16'd45097, 16'd42566, 16'd40177, 16'd37922, 16'd35793,
    16'd33784, 16'd31888, 16'd30098, 16'd28409, 16'd26815, 16'd25310,
    16'd0, 16'd0, 16'd0, 16'd0
  };
endpackage

// File: rtl/audio_tone_gen.sv
// audio_tone_gen: square wave toggling every half_period clocks while enabled;
// a zero half_period is a rest and holds the wave low.
module audio_tone_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] half_period,
  output logic             wave
);
  logic [DIV_W-1:0] cnt_q;
  logic             wave_q;
  // Using >= lets a shrunk half_period restart the count instead of running past it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (!en || half_period == '0) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (cnt_q >= half_period - 1'b1) begin
      cnt_q  <= '0;
      wave_q <= ~wave_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign wave = wave_q;
endmodule

// File: rtl/audio_player.sv
// audio_player: duration/frequency registers, IDLE/PLAY/DONE play sequencer and buzzer output.
// Define AUDIO_NOTE_LUT_EN to map frequency-set operands through the chromatic note table.
module audio_player import audio_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              audioreg,
  input  logic              audioact,
  input  logic              s_cont,
  input  logic [DATA_W-1:0] data_in,
  output logic              cont,
  output logic              audio_out,
  output logic              busy
);
  localparam int TW = $clog2(TICK_DIV);
  state_e           state_q, state_d;
  logic [DUR_W-1:0] dur_reg_q, dur_reg_d, dur_cnt_q, dur_cnt_d;
  logic [DIV_W-1:0] half_period_q, half_period_d, hp_new;
  logic [TW-1:0]    tick_q, tick_d;
  logic             tick_wrap, wave;
`ifdef AUDIO_NOTE_LUT_EN
  assign hp_new = DIV_W'(NOTE_HALF_PERIOD[data_in[3:0]] >> data_in[6:4]);
`else
  assign hp_new = DIV_W'(data_in) << (DIV_W - DATA_W);
`endif
  assign tick_wrap = tick_q == TW'(TICK_DIV - 1);
  always_comb begin
    state_d       = state_q;
    dur_cnt_d     = dur_cnt_q;
    tick_d        = tick_q;
    dur_reg_d     = audioreg ? data_in[DUR_W-1:0] : dur_reg_q;
    half_period_d = (audioact && s_cont) ? hp_new : half_period_q;
    case (state_q)
      IDLE: if (audioact && !s_cont) begin
        state_d   = PLAY;
        dur_cnt_d = dur_reg_q;
        tick_d    = '0;
      end
      PLAY: if (dur_cnt_q == '0) begin
        state_d = DONE;
      end else begin
        tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
        dur_cnt_d = tick_wrap ? dur_cnt_q - 1'b1 : dur_cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      dur_reg_q     <= '0;
      dur_cnt_q     <= '0;
      half_period_q <= '0;
      tick_q        <= '0;
    end else begin
      state_q       <= state_d;
      dur_reg_q     <= dur_reg_d;
      dur_cnt_q     <= dur_cnt_d;
      half_period_q <= half_period_d;
      tick_q        <= tick_d;
    end
  end
  audio_tone_gen #(.DIV_W(DIV_W)) u_tone (
    .clk        (clk),
    .reset      (reset),
    .en         (busy),
    .half_period(half_period_q),
    .wave       (wave)
  );
  assign busy      = state_q == PLAY;
  assign cont      = state_q == DONE;
  assign audio_out = wave && busy;
endmodule

// File: doc/audio_player.md
Name: audio_player

Overview:
- Audio peripheral at the far end of the control unit's audio handshake.
- Consumes `audioreg` (load duration), `audioact` (play / set frequency) and `s_cont` (frequency-adjust qualifier) from the control unit.
- Returns `cont`, the completion flag that releases the PC stall on a blocking play instruction.
- Drives a square-wave `audio_out` to the board buzzer. Data comes from the register-file read bus.

Parameters:
- DATA_W, 8, width of data_in from the register-file read bus
- DIV_W, 16, width of the half-period divider register and counter
- DUR_W, 8, width of the duration register (units of ticks)
- TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz); must be ≥ 2

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- audioreg  input  1  single-cycle strobe: latch data_in into the duration register
- audioact  input  1  audio instruction active; held high by the CPU while stalled
- s_cont  input  1  qualifies audioact as frequency-set (non-blocking) instead of play
- data_in  input  DATA_W  operand from the register file
- cont  output  1  play-complete pulse to the control unit (its `continue` input)
- audio_out  output  1  square-wave audio output
- busy  output  1  high while state is PLAY

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, dur_reg=0, half_period=0, all counters=0. Outputs cont=0, audio_out=0, busy=0.
- Registers:
  - dur_reg (DUR_W) loads data_in[DUR_W-1:0] on any cycle with audioreg=1.
  - half_period (DIV_W) loads on audioact=1 && s_cont=1, in any state: half_period = data_in << (DIV_W-DATA_W).
- FSM has three states: IDLE, PLAY, DONE.
- IDLE:
  - Transition: audioact=1 && s_cont=0 -> PLAY. On that transition: dur_cnt<=dur_reg, tick_cnt<=0, tone_cnt<=0, audio_out<=0.
  - Otherwise stay in IDLE. cont=0.
- PLAY:
  - busy=1.
  - tick_cnt counts 0..TICK_DIV-1 and wraps. At wrap, if dur_cnt!=0, dur_cnt decrements.
  - If dur_cnt==0 at a clock edge -> DONE.
  - Total PLAY length = dur_reg*TICK_DIV+1 cycles; dur_reg=0 gives exactly 1 PLAY cycle.
- DONE: cont=1 for exactly one cycle, then -> IDLE unconditionally.
- Back-to-back plays: if audioact is still high in the IDLE cycle after DONE (next play instruction), a new play starts. The minimum gap is 1 IDLE cycle.
- Tone generation (PLAY only):
  - tone_cnt counts 0..half_period-1. At half_period-1, audio_out toggles and tone_cnt<=0.
  - half_period=0 means a rest: audio_out held at 0.
  - Outside PLAY, audio_out=0.
- Simultaneous events:
  - audioreg during PLAY updates dur_reg only; the running note keeps its loaded dur_cnt.
  - A half_period change during PLAY takes effect at the next tone_cnt wrap. If tone_cnt ≥ new half_period, tone_cnt restarts at 0 on the next cycle.
- audioact=1 && s_cont=1 never starts PLAY and never asserts cont (the control unit does not stall on it).
- Reset asserted mid-play: immediate return to IDLE with audio_out=0 and cont=0; no cont pulse is emitted.

Optional Feature:
- Macro: AUDIO_NOTE_LUT_EN.
- Defined: a frequency-set loads half_period = NOTE_HALF_PERIOD[data_in[3:0]] >> data_in[6:4] (chromatic note plus octave). Note indices 12..15 map to 0 (rest). data_in[7] is ignored.
- Undefined: linear shift mapping as in Behaviour; no LUT is synthesised.

Decomposition:
- Package audio_pkg:
  - state enum (IDLE=2'd0, PLAY=2'd1, DONE=2'd2)
  - NOTE_HALF_PERIOD 16x16 constant table (C..B at 50 MHz, base octave)
  - default widths
- Sub-module audio_tone_gen:
  - contains the half-period counter and toggle flop
  - inputs: clk, reset, en, half_period; output: wave

Test Plan (bench uses TICK_DIV=4, DIV_W=16, DATA_W=8):
- Reset release, then audioreg with data_in=3, then audioact=1/s_cont=0 held -> busy for 13 cycles; cont high exactly 1 cycle, 14 cycles after the audioact sample; then IDLE.
- s_cont=1, audioact=1, data_in=8'h01 (half_period=256); then play with dur=200 -> audio_out toggles every 256 cycles during PLAY; 0 outside PLAY.
- dur_reg=0, play -> 1 PLAY cycle; cont at cycle +2; audio_out stays 0.
- audioact held across DONE with dur=1 -> second play starts after one IDLE cycle; two cont pulses, 7 cycles apart.
- reset driven low mid-PLAY (dur=50) -> audio_out, busy and cont all 0 asynchronously; no cont pulse after reset release.
- With AUDIO_NOTE_LUT_EN defined, frequency-set data_in=8'h19 -> half_period = NOTE_HALF_PERIOD[9]>>1; measured toggle interval matches.
